// File: rtl/pulse_stretcher_fsm_pkg.sv
// ============================================================================
// Module   : pulse_pkg
// Brief    : Shared state encoding and default sizing for pulse_stretcher_fsm.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pulse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      HIGH  = 2'b01,
      GUARD = 2'b11
   } state_t;

   localparam int C_CNT_W_DEF   = 8;
   localparam int C_MIN_LOW_DEF = 1;

endpackage

`default_nettype wire

// File: rtl/pulse_stretcher_fsm_if.sv
// ============================================================================
// Module   : pulse_stretcher_fsm_if
// Brief    : Request/level bundle between pulse producer and the stretcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pulse_stretcher_fsm_if
   import pulse_pkg::*;
#(
   parameter int CNT_W = C_CNT_W_DEF
) ();

   logic             P;
   logic [CNT_W-1:0] LEN;
   logic             L;
   logic             BUSY;
   logic             DROP;

   modport master (output P, output LEN, input  L, input  BUSY, input  DROP);
   modport slave  (input  P, input  LEN, output L, output BUSY, output DROP);

endinterface

`default_nettype wire

// File: rtl/pulse_stretcher_fsm_stretch_counter.sv
// ============================================================================
// Module   : stretch_counter
// Brief    : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stretch_counter #(
   parameter int W = 8
) (
   input  wire logic         CLK,
   input  wire logic         RST,
   input  wire logic         i_load,
   input  wire logic [W-1:0] i_load_val,
   input  wire logic         i_dec,
   output logic              o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher_fsm.sv
// ============================================================================
// Module   : pulse_stretcher_fsm
// Brief    : Stretches request pulses into a level of programmable length with
//            a guaranteed low gap. Define PULSE_RETRIGGER_EN to let requests
//            during the high period extend it instead of queueing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher_fsm
   import pulse_pkg::*;
#(
   parameter int CNT_W   = C_CNT_W_DEF,
   parameter int MIN_LOW = C_MIN_LOW_DEF
) (
   input wire logic              CLK,
   input wire logic              RST,
   pulse_stretcher_fsm_if.slave  bus
);

   localparam logic [CNT_W-1:0] C_GUARD_LOAD = CNT_W'(MIN_LOW - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_pend;
   logic             w_pend_nxt;
   logic             r_l;
   logic             r_busy;
   logic             r_drop;
   logic             w_drop;
   logic             w_cnt_load;
   logic             w_cnt_dec;
   logic             w_cnt_zero;
   logic             w_gcnt_load;
   logic             w_gcnt_dec;
   logic             w_gcnt_zero;
   logic [CNT_W-1:0] w_len_load;

   // LEN of zero behaves like one cycle of high time.
   assign w_len_load = (bus.LEN == '0) ? '0 : bus.LEN - 1'b1;

   stretch_counter #(.W(CNT_W)) u_cnt (
      .CLK        (CLK),
      .RST        (RST),
      .i_load     (w_cnt_load),
      .i_load_val (w_len_load),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   stretch_counter #(.W(CNT_W)) u_gcnt (
      .CLK        (CLK),
      .RST        (RST),
      .i_load     (w_gcnt_load),
      .i_load_val (C_GUARD_LOAD),
      .i_dec      (w_gcnt_dec),
      .o_zero     (w_gcnt_zero)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_pend  <= 1'b0;
         r_l     <= 1'b0;
         r_busy  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_l     <= (w_state_nxt == HIGH);
         r_busy  <= (w_state_nxt != IDLE);
         r_drop  <= w_drop;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_drop      = 1'b0;
      w_cnt_load  = 1'b0;
      w_cnt_dec   = 1'b0;
      w_gcnt_load = 1'b0;
      w_gcnt_dec  = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.P) begin
               w_cnt_load  = 1'b1;
               w_state_nxt = HIGH;
            end
         end

         HIGH: begin
`ifdef PULSE_RETRIGGER_EN
            if (bus.P) begin
               w_cnt_load = 1'b1;
            end else if (w_cnt_zero) begin
               w_gcnt_load = 1'b1;
               w_state_nxt = GUARD;
            end else begin
               w_cnt_dec = 1'b1;
            end
`else
            if (w_cnt_zero) begin
               w_gcnt_load = 1'b1;
               w_state_nxt = GUARD;
            end else begin
               w_cnt_dec = 1'b1;
            end
            if (bus.P) begin
               if (r_pend) w_drop     = 1'b1;
               else        w_pend_nxt = 1'b1;
            end
`endif
         end

         GUARD: begin
            if (w_gcnt_zero) begin
               // A request landing exactly on the last guard cycle is served now.
               if (r_pend || bus.P) begin
                  w_cnt_load  = 1'b1;
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = HIGH;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_gcnt_dec = 1'b1;
               if (bus.P) begin
                  if (r_pend) w_drop     = 1'b1;
                  else        w_pend_nxt = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.L    = r_l;
   assign bus.BUSY = r_busy;
   assign bus.DROP = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher_fsm.sv
// ============================================================================
// Module   : tb_pulse_stretcher_fsm
// Brief    : Scoreboard bench for pulse_stretcher_fsm (MIN_LOW=1 and 3 DUTs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretcher_fsm;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   pulse_stretcher_fsm_if #(.CNT_W(8)) ifa ();
   pulse_stretcher_fsm_if #(.CNT_W(8)) ifb ();

   pulse_stretcher_fsm #(.CNT_W(8), .MIN_LOW(1)) u_dut_a (
      .CLK (CLK),
      .RST (RST),
      .bus (ifa)
   );

   pulse_stretcher_fsm #(.CNT_W(8), .MIN_LOW(3)) u_dut_b (
      .CLK (CLK),
      .RST (RST),
      .bus (ifb)
   );

   typedef struct {
      bit         sel;
      logic [2:0] ex;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic ch(input string s, input int i);
      return (s[i] == "1");
   endfunction

   // One entry per cycle: inputs before the edge, expected {L,BUSY,DROP} after it.
   task automatic seq(input bit sel, input logic [7:0] len, input string p,
                      input string r, input string l, input string b,
                      input string d, input string tag);
      exp_t e;
      for (int i = 0; i < p.len(); i++) begin
         @(negedge CLK);
         RST     = ch(r, i);
         ifa.P   = !sel && ch(p, i);
         ifb.P   = sel && ch(p, i);
         ifa.LEN = len;
         ifb.LEN = len;
         e.sel   = sel;
         e.ex    = {ch(l, i), ch(b, i), ch(d, i)};
         e.tag   = $sformatf("%s[%0d]", tag, i);
         q.push_back(e);
      end
   endtask

   initial begin : p_mon
      exp_t       e;
      logic [2:0] act;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() != 0) begin
            e   = q.pop_front();
            act = e.sel ? {ifb.L, ifb.BUSY, ifb.DROP} : {ifa.L, ifa.BUSY, ifa.DROP};
            n_tests++;
            if (act !== e.ex) begin
               n_fail++;
               $display("FAIL %s: L/BUSY/DROP got %b required %b", e.tag, act, e.ex);
            end
         end
      end
   end

   initial begin : p_stim
      ifa.P = 1'b0; ifa.LEN = '0;
      ifb.P = 1'b0; ifb.LEN = '0;

      seq(0, 8'd0, "11", "11", "00", "00", "00", "reset_a");
      seq(1, 8'd0, "11", "11", "00", "00", "00", "reset_b");

      seq(0, 8'd3, "100000", "000000", "111000", "111100", "000000", "basic");
      seq(0, 8'd0, "1000", "0000", "1000", "1100", "0000", "zero_len");
`ifdef PULSE_RETRIGGER_EN
      seq(0, 8'd4, "100100000", "000000000", "111111100", "111111110",
          "000000000", "retrigger");
`else
      seq(0, 8'd4, "11100000000", "00000000000", "11110111100", "11111111110",
          "00100000000", "queue_drop");
`endif
      seq(1, 8'd2, "100001000000", "000000000000", "110001100000", "111111111100",
          "000000000000", "guard_edge");
      seq(1, 8'd1, "101100000", "000000000", "100010000", "111111110",
          "000100000", "guard_pend");
      seq(0, 8'd5, "1100000000", "0010000000", "1100000000", "1100000000",
          "0000000000", "reset_mid");

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
      #2;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: pending entries got %0d required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pulse_stretcher_fsm.md
# pulse_stretcher_fsm

Converts single-cycle request pulses `P` into a clean level `L` that is held high for a programmable number of cycles, then forced low for a guaranteed minimum gap. It is the pulse-to-level counterpart of the team's rising-edge detector: feeding `L` into that detector regenerates exactly one pulse per accepted request. It sits between pulse-producing control logic and level-sensitive consumers such as lock actuators, indicator LEDs and handshake lines.

## Interface
- `CNT_W`, 8: width of the `LEN` input and of the hold counter.
- `MIN_LOW`, 1: guaranteed low cycles between two high periods; legal range 1 to 2^`CNT_W`-1.
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `P`  in  1  request pulse, sampled every rising edge.
- `LEN`  in  `CNT_W`  high-time in cycles; 0 is treated as 1.
- `L`  out  1  stretched level, registered.
- `BUSY`  out  1  high whenever the state is not IDLE, registered.
- `DROP`  out  1  one-cycle pulse when a request is discarded, registered.

## Operation
- States: IDLE=2'b00, HIGH=2'b01, GUARD=2'b11. The encoding 2'b10 is unreachable and returns to IDLE on the next edge.
- Internal registers: hold counter `cnt` (`CNT_W` bits), guard counter `gcnt` (`CNT_W` bits), one-deep `pend` flag.
- Load value is max(`LEN`,1)-1. `LEN` is sampled only at the edge where the FSM enters HIGH or reloads.
- IDLE, `L`=0:
  - `P`=1: load `cnt`, go to HIGH.
  - Otherwise stay in IDLE.
- HIGH, `L`=1:
  - `cnt`==0: load `gcnt`=`MIN_LOW`-1 and go to GUARD.
  - Otherwise decrement `cnt`.
- GUARD, `L`=0:
  - `gcnt`==0 and (`pend` or `P`): load `cnt`, clear `pend`, go to HIGH.
  - `gcnt`==0 with no request: go to IDLE.
  - Otherwise decrement `gcnt`.
- A request that arrives while not serviceable (HIGH without retrigger, or GUARD with `gcnt`!=0):
  - `pend`=0: set `pend`.
  - `pend`=1: assert `DROP` for one cycle and discard the request.
- Simultaneous events:
  - `P`=1 in HIGH at `cnt`==0 without retrigger: `pend` is set and the FSM still goes to GUARD.
  - `P`=1 in GUARD at `gcnt`==0: serviced immediately; `pend` is not set.
- Reset values: `L`=0, `BUSY`=0, `DROP`=0, state=IDLE, `cnt`=0, `gcnt`=0, `pend`=0. Reset mid-operation aborts the high period and clears any pending request; `DROP` is not raised.

## Timing
- Latency: `P` high at edge k gives `L`=1 from edge k to edge k+N, where N=max(`LEN`,1). `L` is high for exactly N cycles.
- `L` stays low for at least `MIN_LOW` cycles between high periods.
- A back-to-back serviced request gives the period N+`MIN_LOW`.
- `BUSY` rises together with `L`. It falls at the edge GUARD→IDLE, i.e. `MIN_LOW` cycles after `L` falls.
- `DROP` is high for exactly the one cycle following the edge on which the request was discarded.

## Configuration
- `PULSE_RETRIGGER_EN` defined:
  - `P`=1 in HIGH reloads `cnt` with the current `LEN`; `L` stays high without a gap.
  - Reload takes priority over the `cnt`==0 exit.
  - `pend` is never set from HIGH.
- `PULSE_RETRIGGER_EN` undefined: HIGH-state requests follow the pend/DROP rule above.
- Behaviour in IDLE and GUARD is identical in both builds.

## Structure
- Shared package `pulse_pkg` holds:
  - the state typedef and the three encodings;
  - the default `CNT_W` and `MIN_LOW` constants.
- One sub-module, `stretch_counter`: a loadable down-counter with a zero flag. It is instantiated twice, for `cnt` and for `gcnt`.
- The FSM, `pend` and the output registers live in the top module.

## Test plan
- Basic stretch: `LEN`=3, `P` at edge 0 → `L`=1 for edges 0–3 only; `BUSY` falls at edge 4 (`MIN_LOW`=1).
- Zero length: `LEN`=0, single `P` → `L` high for exactly 1 cycle.
- Queue and drop, retrigger off, `LEN`=4:
  - `P` at edges 0, 1, 2 → second pulse is pended, third pulse raises `DROP` for one cycle.
  - `L` is high 4 cycles, low 1 cycle, then high 4 cycles.
- Retrigger on, `LEN`=4: `P` at edges 0 and 3 → `L` continuously high from edge 0 to edge 7.
- Guard boundary, `MIN_LOW`=3:
  - `P` exactly at the `gcnt`==0 edge → immediate HIGH with `L` low for exactly 3 cycles.
  - No `pend` is set and no `DROP` is raised.
- Reset mid-HIGH with `pend`=1 → next edge has `L`=0, `BUSY`=0, `DROP`=0, and no later high period.
